// File: rtl/mac_job_scheduler.sv
// Two-requester round-robin job scheduler feeding one MAC unit; streams NUM_OPS operand pairs per job.
// Optional WAIT watchdog enabled by defining MAC_SCHED_TIMEOUT_EN.
module mac_job_scheduler #(
  parameter int NUM_OPS           = 8,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [3:0]                   req_mode,
  input  logic [1:0]                   op_valid,
  output logic [1:0]                   op_ready,
  input  logic [15:0]                  op_a,
  input  logic [15:0]                  op_b,
  output logic                         mac_enable,
  output logic                         mac_clear,
  output logic [1:0]                   mac_precision_mode,
  output logic [7:0]                   mac_operand_a,
  output logic [7:0]                   mac_operand_b,
  input  logic                         mac_valid,
  input  logic [ACCUMULATOR_WIDTH-1:0] mac_acc_int,
  input  logic [15:0]                  mac_acc_fp16,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_id,
  output logic [1:0]                   res_mode,
  output logic [ACCUMULATOR_WIDTH-1:0] res_int,
  output logic [15:0]                  res_fp16,
  output logic                         res_err,
  output logic                         busy
);

  localparam int CW = $clog2(NUM_OPS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, RESULT} state_t;

  state_t                       state_q, state_d;
  logic                         gnt_q, gnt_d;
  logic [1:0]                   mode_q, mode_d;
  logic                         prio_q, prio_d;
  logic [CW-1:0]                beat_q, beat_d;
  logic [TW-1:0]                wait_cnt_q, wait_cnt_d;
  logic [ACCUMULATOR_WIDTH-1:0] res_int_q, res_int_d;
  logic [15:0]                  res_fp16_q, res_fp16_d;
  logic                         res_err_q, res_err_d;
  logic                         g_sel_s;
  logic [1:0]                   g_mode_s;

  // Round-robin pick: prio_q owns the slot unless it is idle.
  always_comb begin
    if (req_valid[prio_q]) begin
      g_sel_s = prio_q;
    end else begin
      g_sel_s = ~prio_q;
    end
    g_mode_s = req_mode[{g_sel_s, 1'b0} +: 2];
  end

  // Next-state and job bookkeeping.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    mode_d     = mode_q;
    prio_d     = prio_q;
    beat_d     = beat_q;
    wait_cnt_d = wait_cnt_q;
    res_int_d  = res_int_q;
    res_fp16_d = res_fp16_q;
    res_err_d  = res_err_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gnt_d  = g_sel_s;
          mode_d = g_mode_s;
          prio_d = ~g_sel_s;
          if (g_mode_s == 2'b11) begin
            res_int_d  = '0;
            res_fp16_d = 16'h0000;
            res_err_d  = 1'b1;
            state_d    = RESULT;
          end else begin
            state_d = CLEAR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        beat_d     = '0;
        wait_cnt_d = '0;
        state_d    = STREAM;
      end
      STREAM: begin
        if (op_valid[gnt_q]) begin
          if (beat_q == CW'(NUM_OPS - 1)) begin
            beat_d  = '0;
            state_d = WAIT;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + TW'(1);
        if (mac_valid) begin
          res_int_d  = mac_acc_int;
          res_fp16_d = mac_acc_fp16;
          res_err_d  = 1'b0;
          state_d    = RESULT;
        end
`ifdef MAC_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_int_d  = '0;
          res_fp16_d = 16'h0000;
          res_err_d  = 1'b1;
          state_d    = RESULT;
        end
`endif
        else begin
          state_d = WAIT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESULT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and job registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      mode_q     <= 2'b00;
      prio_q     <= 1'b0;
      beat_q     <= '0;
      wait_cnt_q <= '0;
      res_int_q  <= '0;
      res_fp16_q <= 16'h0000;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      mode_q     <= mode_d;
      prio_q     <= prio_d;
      beat_q     <= beat_d;
      wait_cnt_q <= wait_cnt_d;
      res_int_q  <= res_int_d;
      res_fp16_q <= res_fp16_d;
      res_err_q  <= res_err_d;
    end
  end

  // Output decode; rst forces everything quiet while holding the MAC in clear.
  always_comb begin
    req_ready          = 2'b00;
    op_ready           = 2'b00;
    mac_enable         = 1'b0;
    mac_clear          = 1'b0;
    mac_precision_mode = 2'b00;
    mac_operand_a      = 8'h00;
    mac_operand_b      = 8'h00;
    res_valid          = 1'b0;
    res_id             = 1'b0;
    res_mode           = 2'b00;
    res_int            = '0;
    res_fp16           = 16'h0000;
    res_err            = 1'b0;
    busy               = 1'b0;
    if (rst) begin
      mac_clear = 1'b1;
    end else begin
      res_id   = gnt_q;
      res_mode = mode_q;
      res_int  = res_int_q;
      res_fp16 = res_fp16_q;
      res_err  = res_err_q;
      busy     = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            req_ready[g_sel_s] = 1'b1;
          end else begin
            req_ready = 2'b00;
          end
        end
        CLEAR: begin
          mac_clear          = 1'b1;
          mac_precision_mode = mode_q;
        end
        STREAM: begin
          op_ready[gnt_q]    = 1'b1;
          mac_enable         = op_valid[gnt_q];
          mac_precision_mode = mode_q;
          mac_operand_a      = op_a[{gnt_q, 3'b000} +: 8];
          mac_operand_b      = op_b[{gnt_q, 3'b000} +: 8];
        end
        WAIT:    mac_precision_mode = mode_q;
        RESULT:  res_valid = 1'b1;
        default: busy = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler with a small behavioural MAC attached.
// Vector table for complete jobs plus hand sequences for arbitration, reset and watchdog.
module tb_mac_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, op_valid, op_ready;
  logic [3:0]  req_mode;
  logic [15:0] op_a, op_b;
  logic        mac_enable, mac_clear, mac_valid;
  logic [1:0]  mac_precision_mode;
  logic [7:0]  mac_operand_a, mac_operand_b;
  logic [31:0] mac_acc_int;
  logic [15:0] mac_acc_fp16;
  logic        res_valid, res_ready, res_id, res_err, busy;
  logic [1:0]  res_mode;
  logic [31:0] res_int;
  logic [15:0] res_fp16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_job_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_enable(mac_enable), .mac_clear(mac_clear), .mac_precision_mode(mac_precision_mode),
    .mac_operand_a(mac_operand_a), .mac_operand_b(mac_operand_b), .mac_valid(mac_valid),
    .mac_acc_int(mac_acc_int), .mac_acc_fp16(mac_acc_fp16), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_mode(res_mode), .res_int(res_int),
    .res_fp16(res_fp16), .res_err(res_err), .busy(busy)
  );

  // Behavioural MAC: signed products, result valid two cycles after NUM_OPS enables.
  logic        mac_hold = 1'b0;
  logic [31:0] acc;
  logic [15:0] prod;
  int          mcnt, mlat;
  always_comb begin
    if (mac_precision_mode == 2'b01)
      prod = {{12{mac_operand_a[3]}}, mac_operand_a[3:0]} * {{12{mac_operand_b[3]}}, mac_operand_b[3:0]};
    else
      prod = {{8{mac_operand_a[7]}}, mac_operand_a} * {{8{mac_operand_b[7]}}, mac_operand_b};
  end
  always @(posedge clk) begin
    mac_valid <= 1'b0;
    if (mac_clear) begin
      acc <= 32'd0; mcnt <= 0; mlat <= 0;
    end else begin
      if (mac_enable) begin
        acc  <= acc + {{16{prod[15]}}, prod};
        mcnt <= mcnt + 1;
      end
      if (mcnt == 8) begin
        mlat <= mlat + 1;
        if (mlat == 1 && !mac_hold) begin
          mac_valid <= 1'b1; mcnt <= 0; mlat <= 0;
        end
      end
    end
  end
  assign mac_acc_int  = acc;
  assign mac_acc_fp16 = acc[15:0] ^ 16'hA5A5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] bub;
    int          rdy_dly;
    logic [31:0] exp_int;
    logic        exp_err;
  } vec_t;

  // Streams until nbeats enables were seen; called at a negedge after CLEAR.
  task automatic do_stream(input logic r, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] bub, input int nbeats, input logic [1:0] mode);
    int en = 0;
    int k = 0;
    logic [1:0] oh;
    oh = r ? 2'b10 : 2'b01;
    @(posedge clk);
    while (en < nbeats && k < 40) begin
      @(negedge clk);
      op_valid[r] = ~bub[k];
      op_a[r*8 +: 8] = a;
      op_b[r*8 +: 8] = b;
      #1;
      chk("op_ready", {30'd0, op_ready}, {30'd0, oh});
      chk("mac_enable", {31'd0, mac_enable}, {31'd0, op_valid[r]});
      chk("mac_mode", {30'd0, mac_precision_mode}, {30'd0, mode});
      if (op_valid[r]) begin
        chk("mac_opa", {24'd0, mac_operand_a}, {24'd0, a});
        chk("mac_opb", {24'd0, mac_operand_b}, {24'd0, b});
      end
      if (mac_enable) en++;
      k++;
      if (en < nbeats) @(posedge clk);
    end
    chk("enable_count", en, nbeats);
  endtask

  // One complete job; entered and left at negedge+1.
  task automatic run_job(input vec_t v, input logic keep_other);
    int k = 0;
    logic [1:0] oh;
    oh = v.r ? 2'b10 : 2'b01;
    req_valid[v.r] = 1'b1;
    if (keep_other) req_valid[~v.r] = 1'b1;
    req_mode[v.r*2 +: 2] = v.mode;
    #1 chk("grant", {30'd0, req_ready}, {30'd0, oh});
    @(posedge clk);
    @(negedge clk);
    req_valid[v.r] = 1'b0;
    #1 chk("busy", {31'd0, busy}, 32'd1);
    if (v.mode != 2'b11) begin
      chk("clear_pulse", {30'd0, mac_clear, mac_enable}, 32'd2);
      do_stream(v.r, v.a, v.b, v.bub, 8, v.mode);
      @(posedge clk);
      @(negedge clk);
      op_valid = 2'b00;
      #1;
    end
    while (!res_valid && k < 30) begin
      @(negedge clk); #1; k++;
    end
    chk("res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_id", {31'd0, res_id}, {31'd0, v.r});
    chk("res_mode", {30'd0, res_mode}, {30'd0, v.mode});
    chk("res_int", res_int, v.exp_int);
    chk("res_fp16", {16'd0, res_fp16}, v.exp_err ? 32'd0 : {16'd0, v.exp_int[15:0] ^ 16'hA5A5});
    chk("res_err", {31'd0, res_err}, {31'd0, v.exp_err});
    for (int i = 0; i < v.rdy_dly; i++) begin
      @(negedge clk); #1;
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_id", {31'd0, res_id}, {31'd0, v.r});
      chk("hold_int", res_int, v.exp_int);
      chk("hold_err", {31'd0, res_err}, {31'd0, v.exp_err});
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    chk("post_valid", {31'd0, res_valid}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  vec_t tbl[5];
  vec_t va, vb, vr;

  initial begin
    tbl[0] = '{1'b0, 2'b00, 8'd10, 8'd5,  16'h0000, 0, 32'd400,       1'b0};
    tbl[1] = '{1'b1, 2'b01, 8'hF3, 8'h05, 16'h0048, 0, 32'd120,       1'b0};
    tbl[2] = '{1'b1, 2'b00, 8'hFD, 8'd7,  16'h0000, 5, 32'hFFFFFF58,  1'b0};
    tbl[3] = '{1'b0, 2'b11, 8'd0,  8'd0,  16'h0000, 2, 32'd0,         1'b1};
    tbl[4] = '{1'b0, 2'b00, 8'h80, 8'h80, 16'h0101, 0, 32'h00020000,  1'b0};
    va = '{1'b0, 2'b00, 8'd1,   8'd2,   16'h0000, 0, 32'd16,     1'b0};
    vb = '{1'b1, 2'b00, 8'd2,   8'd3,   16'h0000, 0, 32'd48,     1'b0};
    vr = '{1'b0, 2'b00, 8'd127, 8'd127, 16'h0000, 0, 32'd129032, 1'b0};

    rst = 1'b1; req_valid = 2'b00; req_mode = 4'h0; op_valid = 2'b00;
    op_a = 16'h0000; op_b = 16'h0000; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_outputs_zero", {31'd0, |{req_ready, op_ready, mac_enable, mac_precision_mode,
        mac_operand_a, mac_operand_b, res_valid, res_id, res_mode, res_int, res_fp16, res_err, busy}}, 32'd0);
    chk("rst_mac_clear", {31'd0, mac_clear}, 32'd1);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_clear", {31'd0, mac_clear}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Simultaneous requests twice: requester 0 wins both rounds.
    run_job(va, 1'b1);
    run_job(vb, 1'b0);
    run_job(va, 1'b1);
    run_job(vb, 1'b0);

    for (int i = 0; i < 5; i++) run_job(tbl[i], 1'b0);

    // Reset during STREAM after four beats.
    req_valid[0] = 1'b1; req_mode[1:0] = 2'b00;
    #1 chk("rst_job_grant", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    do_stream(1'b0, 8'd127, 8'd127, 16'h0000, 4, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    op_valid[0] = 1'b1;
    #1;
    chk("midrst_outputs_zero", {31'd0, |{req_ready, op_ready, mac_enable, mac_precision_mode,
        mac_operand_a, mac_operand_b, res_valid, res_id, res_mode, res_int, res_fp16, res_err, busy}}, 32'd0);
    chk("midrst_mac_clear", {31'd0, mac_clear}, 32'd1);
    @(negedge clk);
    rst = 1'b0; op_valid = 2'b00;
    #1;
    chk("midrst_after_clear", {31'd0, mac_clear}, 32'd0);
    chk("midrst_after_busy", {31'd0, busy}, 32'd0);
    chk("midrst_no_result", {31'd0, res_valid}, 32'd0);
    run_job(vr, 1'b0);

    // MAC never answers.
    mac_hold = 1'b1;
    req_valid[1] = 1'b1; req_mode[3:2] = 2'b00;
    #1 chk("hang_grant", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    do_stream(1'b1, 8'd3, 8'd3, 16'h0000, 8, 2'b00);
    @(negedge clk);
    op_valid = 2'b00;
    begin
      int k = 0;
      while (!res_valid && k < 100) begin
        @(negedge clk); #1; k++;
      end
    end
`ifdef MAC_SCHED_TIMEOUT_EN
    chk("timeout_valid", {31'd0, res_valid}, 32'd1);
    chk("timeout_err", {31'd0, res_err}, 32'd1);
    chk("timeout_int", res_int, 32'd0);
`else
    chk("hang_no_result", {31'd0, res_valid}, 32'd0);
    chk("hang_busy", {31'd0, busy}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_job_scheduler.md
MAC_JOB_SCHEDULER -- requirements
Module: mac_job_scheduler

Interface
REQ-001 SHALL have parameters NUM_OPS (default 8, operand pairs per job; must equal the MAC's NUM_OPERATIONS), ACCUMULATOR_WIDTH (default 32), TIMEOUT_CYCLES (default 64, watchdog limit, power of two).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  requester r has a job pending.
- req_ready  out  2  one-hot grant pulse; job accepted.
- req_mode  in  4  precision mode, bits [2r+1:2r]: 00 INT8, 01 INT4, 10 FP8, 11 reserved.
- op_valid  in  2  requester r operand pair valid.
- op_ready  out  2  operand pair accepted.
- op_a  in  16  operand A, bits [8r+7:8r].
- op_b  in  16  operand B, bits [8r+7:8r].
- mac_enable  out  1  MAC enable.
- mac_clear  out  1  MAC clear.
- mac_precision_mode  out  2  MAC precision mode.
- mac_operand_a  out  8  MAC operand A.
- mac_operand_b  out  8  MAC operand B.
- mac_valid  in  1  MAC result valid.
- mac_acc_int  in  ACCUMULATOR_WIDTH  MAC integer result.
- mac_acc_fp16  in  16  MAC FP16 result.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_id  out  1  requester index for the result.
- res_mode  out  2  precision mode of the job.
- res_int  out  ACCUMULATOR_WIDTH  integer result.
- res_fp16  out  16  FP16 result.
- res_err  out  1  job error.
- busy  out  1  high in any state except IDLE.

Function
REQ-003 SHALL implement FSM IDLE -> CLEAR -> STREAM -> WAIT -> RESULT -> IDLE.
REQ-004 IDLE: if any req_valid is high, SHALL grant one requester by round-robin, pulse req_ready[g] for one cycle, latch g and req_mode[g], and go to CLEAR.
REQ-005 Round-robin SHALL give priority to the requester not granted last; after reset, requester 0 has priority.
REQ-006 A job with reserved mode 11 SHALL be granted, skip CLEAR/STREAM/WAIT, and go to RESULT with res_err=1 and res_int=0, res_fp16=0.
REQ-007 CLEAR: mac_clear SHALL be 1 for exactly one cycle and mac_enable 0; next state STREAM.
REQ-008 STREAM: op_ready[g]=1, op_ready of the other requester=0.
REQ-009 STREAM: mac_enable=op_valid[g] and mac_operand_a/b=op_a/op_b slice g, combinational, zero latency.
REQ-010 STREAM: a beat counter SHALL increment on each op_valid[g]&op_ready[g]; after beat NUM_OPS, go to WAIT.
REQ-011 STREAM: cycles with op_valid[g]=0 SHALL leave mac_enable=0 and the counter unchanged.
REQ-012 mac_operand_a/b SHALL be 0 outside STREAM; mac_precision_mode SHALL hold the latched mode from CLEAR through WAIT.
REQ-013 WAIT: on mac_valid=1, SHALL register mac_acc_int and mac_acc_fp16 into res_int and res_fp16, set res_err=0, and go to RESULT.
REQ-014 RESULT: res_valid=1; res_id, res_mode, res_int, res_fp16 and res_err SHALL be stable until res_valid&res_ready.
REQ-015 On res_valid&res_ready, SHALL return to IDLE; a new grant is possible no earlier than the following cycle.
REQ-016 req_valid changes during a job SHALL be ignored; the losing requester is served after the current job.
REQ-017 Minimum job latency, with no operand bubbles and res_ready=1: grant + 1 CLEAR + NUM_OPS STREAM + MAC latency + 1 RESULT cycle.

Reset
REQ-018 While rst=1 at a clock edge, SHALL enter IDLE and clear the counters and round-robin pointer.
REQ-019 During reset, all outputs SHALL be 0, except mac_clear=1 so the MAC is cleared.
REQ-020 Reset mid-job SHALL abandon the job with no result emitted; on the first cycle after reset, mac_clear=0 and the FSM is in IDLE.

Configuration
REQ-021 Macro MAC_SCHED_TIMEOUT_EN defined: a counter runs in WAIT; if mac_valid is absent for TIMEOUT_CYCLES cycles, SHALL go to RESULT with res_err=1, res_int=0, res_fp16=0.
REQ-022 Macro MAC_SCHED_TIMEOUT_EN undefined: WAIT SHALL hold indefinitely and res_err SHALL be set only by REQ-006.

Verification
REQ-023 Requester 0, INT8, eight pairs 10*5 with MAC attached -> res_int=400, res_id=0, res_mode=00, res_err=0.
REQ-024 Both requesters valid in the same cycle after reset -> req0 served first, req1 second. A repeated simultaneous pair -> req0 served first again, because req1 was granted last.
REQ-025 Requester 1, INT4, pairs 0xF3*0x05, op_valid low on beats 3 and 6 -> mac_enable low on those cycles, exactly 8 enables, res_int=120.
REQ-026 res_ready held low for 5 cycles in RESULT -> res_valid and all res_* fields stable for those 5 cycles; single handshake, then IDLE.
REQ-027 With MAC_SCHED_TIMEOUT_EN defined and mac_valid tied low -> res_err=1 after 64 WAIT cycles. Without the macro -> busy stays 1 and there is no result.
REQ-028 rst pulsed at STREAM beat 4 -> all outputs 0 during reset except mac_clear=1. A subsequent 127*127 x8 job -> res_int=129032.
